// File: rtl/conv_output_stage_pkg.sv
// Shared settings for the convolution output stage.
// Holds the default datapath sizing and the clog2 helper used to size
// the FIFO pointers.
package conv_output_stage_pkg;

  // Smallest n with 2**n >= value. Returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((32'd1 << bits) < value) bits++;
    return bits;
  endfunction

  localparam int unsigned DATA_SIZE      = 16;
  localparam int unsigned EXTRA_BITS     = 4;
  localparam int unsigned FULL_SIZE      = 2 * DATA_SIZE + EXTRA_BITS;
  localparam int unsigned OUT_SHIFT      = 15;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned FIFO_ADDR_SIZE = clog2(FIFO_DEPTH);

endpackage

// File: rtl/conv_sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    write request; accepted when not full or when a read
//                     is accepted in the same cycle
//   rd_en             pop the head (ignored when empty)
//   rd_data           current head; zero while empty
//   full, empty       occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable
// when the address bits match.
module conv_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  import conv_output_stage_pkg::clog2;

  localparam int unsigned     ADDR_SIZE = clog2(DEPTH);
  localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE:0]   rd_ptr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 do_wr;
  logic                 do_rd;

  always_comb begin
    wr_addr = wr_ptr[ADDR_SIZE-1:0];
    rd_addr = rd_ptr[ADDR_SIZE-1:0];
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) && (wr_addr == rd_addr);
    do_rd   = rd_en && !empty;
    // A read in the same cycle frees the slot being written on a full FIFO.
    do_wr   = wr_en && (!full || do_rd);
    rd_data = empty ? '0 : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/conv_output_stage.sv
// Output conditioning for the convolution adder tree: round-half-up,
// arithmetic shift, saturate to DATA_SIZE, then buffer in a small FIFO
// presented as a valid/ready stream. The input side never stalls; a
// sample arriving at a full FIFO with no read is dropped and flagged.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   input_data          signed FULL_SIZE accumulator result
//   input_data_valid    input_data qualifies this cycle
//   output_data         signed DATA_SIZE sample at the FIFO head
//   output_data_valid   FIFO not empty
//   output_data_ready   consumer takes the head this cycle
//   sat_count           saturated-sample count, sticks at 0xFFFF
//   overflow_flag       sticky drop indicator, cleared only by reset
module conv_output_stage #(
  parameter int unsigned FULL_SIZE  = conv_output_stage_pkg::FULL_SIZE,
  parameter int unsigned DATA_SIZE  = conv_output_stage_pkg::DATA_SIZE,
  parameter int unsigned OUT_SHIFT  = conv_output_stage_pkg::OUT_SHIFT,
  parameter int unsigned FIFO_DEPTH = conv_output_stage_pkg::FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FULL_SIZE-1:0] input_data,
  input  logic                 input_data_valid,
  output logic [DATA_SIZE-1:0] output_data,
  output logic                 output_data_valid,
  input  logic                 output_data_ready,
  output logic [15:0]          sat_count,
  output logic                 overflow_flag
);

  localparam logic signed [FULL_SIZE:0] SUM_ONE   = {{FULL_SIZE{1'b0}}, 1'b1};
  localparam logic signed [FULL_SIZE:0] ROUND_ADD = SUM_ONE << (OUT_SHIFT - 1);
  localparam logic signed [FULL_SIZE:0] SAT_MAX   =
    {{(FULL_SIZE + 2 - DATA_SIZE){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
  localparam logic signed [FULL_SIZE:0] SAT_MIN   =
    {{(FULL_SIZE + 2 - DATA_SIZE){1'b1}}, {(DATA_SIZE - 1){1'b0}}};
  localparam logic [DATA_SIZE-1:0] WORD_MAX = {1'b0, {(DATA_SIZE - 1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] WORD_MIN = {1'b1, {(DATA_SIZE - 1){1'b0}}};

  logic                        s1_valid;
  logic signed [FULL_SIZE:0]   s1_sum;
  logic signed [FULL_SIZE:0]   shifted;
  logic                        sat_pos;
  logic                        sat_neg;
  logic                        s2_valid;
  logic                        s2_sat;
  logic [DATA_SIZE-1:0]        s2_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        rd_fire;
  logic                        drop;

  // Stage 1: one extra bit of headroom so the rounding add cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= input_data_valid;
      s1_sum   <= $signed({input_data[FULL_SIZE-1], input_data}) + ROUND_ADD;
    end
  end

  always_comb begin
    shifted = s1_sum >>> OUT_SHIFT;
    sat_pos = shifted > SAT_MAX;
    sat_neg = shifted < SAT_MIN;
  end

  // Stage 2: clamp to the output range, keeping the saturation event.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sat   <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sat   <= sat_pos || sat_neg;
      if (sat_pos)      s2_data <= WORD_MAX;
      else if (sat_neg) s2_data <= WORD_MIN;
      else              s2_data <= shifted[DATA_SIZE-1:0];
    end
  end

  always_comb begin
    output_data_valid = !fifo_empty;
    rd_fire           = output_data_valid && output_data_ready;
    drop              = s2_valid && fifo_full && !rd_fire;
  end

  conv_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s2_valid),
    .wr_data (s2_data),
    .rd_en   (rd_fire),
    .rd_data (output_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Saturations are counted whether or not the sample survives the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count     <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (s2_valid && s2_sat && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
      if (drop)
        overflow_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_output_stage.sv
module tb_conv_output_stage;

  localparam int unsigned FULL  = 36;
  localparam int unsigned DATA  = 16;
  localparam int unsigned SHIFT = 15;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [FULL-1:0] input_data;
  logic            input_data_valid;
  logic [DATA-1:0] output_data;
  logic            output_data_valid;
  logic            output_data_ready;
  logic [15:0]     sat_count;
  logic            overflow_flag;

  always #5 clk = ~clk;

  conv_output_stage #(
    .FULL_SIZE  (FULL),
    .DATA_SIZE  (DATA),
    .OUT_SHIFT  (SHIFT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .input_data        (input_data),
    .input_data_valid  (input_data_valid),
    .output_data       (output_data),
    .output_data_valid (output_data_valid),
    .output_data_ready (output_data_ready),
    .sat_count         (sat_count),
    .overflow_flag     (overflow_flag)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          v;
    logic [15:0] val;
    bit          sat;
  } item_t;

  // Reference: samples in flight (two-edge delay) and the buffered queue.
  item_t       pipe [2];
  logic [15:0] mq[$];
  logic [15:0] m_sat;
  bit          m_ovf;
  logic [15:0] got[$];
  logic [15:0] expq[$];

  // Floor((x + 2^14) / 2^15), clamped to the signed 16-bit range.
  function automatic logic [15:0] ref_out(input longint x, output bit sat);
    longint num;
    longint q;
    num = x + 64'sd16384;
    q   = num / 64'sd32768;
    if ((num % 64'sd32768) != 0 && num < 0) q = q - 1;
    sat = 1'b0;
    if (q > 64'sd32767) begin sat = 1'b1; return 16'h7FFF; end
    if (q < -64'sd32768) begin sat = 1'b1; return 16'h8000; end
    return q[15:0];
  endfunction

  function automatic longint rand_in();
    longint w;
    w = $signed({$urandom, $urandom});
    if ($urandom_range(1, 0) == 1) return w >>> 28;
    return w >>> 36;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input longint x, input bit rdy);
    item_t nw;
    bit    s;
    if (rst) begin
      mq.delete();
      pipe[0].v = 1'b0;
      pipe[1].v = 1'b0;
      m_sat = '0;
      m_ovf = 1'b0;
      return;
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (pipe[1].v) begin
      if (pipe[1].sat && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
      if (mq.size() < DEPTH) mq.push_back(pipe[1].val);
      else m_ovf = 1'b1;
    end
    pipe[1] = pipe[0];
    nw.v   = v;
    nw.val = ref_out(x, s);
    nw.sat = s;
    pipe[0] = nw;
  endtask

  // Entered and left at a falling edge: compare, drive, clock, update model.
  task automatic step(input bit rst, input bit v, input longint x, input bit rdy);
    check("valid", {63'd0, output_data_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) check("head", {48'd0, output_data}, {48'd0, mq[0]});
    check("sat_count", {48'd0, sat_count}, {48'd0, m_sat});
    check("overflow", {63'd0, overflow_flag}, {63'd0, m_ovf});
    if (output_data_valid && rdy && !rst) got.push_back(output_data);
    reset             = rst;
    input_data_valid  = v;
    input_data        = x[FULL-1:0];
    output_data_ready = rdy;
    @(posedge clk);
    model_edge(rst, v, x, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, rdy);
  endtask

  task automatic send(input longint x, input bit rdy);
    bit s;
    expq.push_back(ref_out(x, s));
    step(1'b0, 1'b1, x, rdy);
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < got.size()) check(tag, {48'd0, got[i]}, {48'd0, expq[i]});
  endtask

  longint rin [5];
  longint sin [3];
  longint x;
  int     sent;
  bit     v;
  bit     rdy;

  initial begin
    reset = 1'b1;
    input_data_valid = 1'b0;
    input_data = '0;
    output_data_ready = 1'b0;
    pipe[0].v = 1'b0;
    pipe[1].v = 1'b0;
    m_sat = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("reset_valid", {63'd0, output_data_valid}, 64'd0);
    check("reset_data", {48'd0, output_data}, 64'd0);
    check("reset_sat", {48'd0, sat_count}, 64'd0);
    check("reset_ovf", {63'd0, overflow_flag}, 64'd0);

    // Rounding at exact halves and just below.
    rin = '{64'sd16384, 64'sd16383, -64'sd16384, -64'sd16385, 64'sd49152};
    got.delete();
    expq.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rin[i], 1'b1);
    expq = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002};
    idle(5, 1'b1);
    check_got("round");
    check("round_sat", {48'd0, sat_count}, 64'd0);

    // Saturation at both rails and the largest non-saturating value.
    sin = '{64'sd2147483648, -64'sd2147483648, 64'sd32767 * 64'sd32768};
    got.delete();
    expq.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, sin[i], 1'b1);
    expq = '{16'h7FFF, 16'h8000, 16'h7FFF};
    idle(5, 1'b1);
    check_got("sat");
    check("sat_total", {48'd0, sat_count}, 64'd2);

    // Full FIFO with a read in the same cycle as the fifth write.
    got.delete();
    expq.delete();
    for (int i = 0; i < 5; i++) send(rand_in(), 1'b0);
    idle(1, 1'b0);
    idle(8, 1'b1);
    check_got("full_rw");
    check("full_rw_ovf", {63'd0, overflow_flag}, 64'd0);

    // Sustained random stream: throttled so the FIFO never overflows.
    got.delete();
    expq.delete();
    sent = 0;
    for (int c = 0; c < 2000 && sent < 100; c++) begin
      rdy = ($urandom_range(1, 0) == 1);
      v = ($urandom_range(1, 0) == 1) &&
          (mq.size() + int'(pipe[0].v) + int'(pipe[1].v) < DEPTH);
      if (v) begin
        sent++;
        send(longint'(sent) * 64'sd32768, rdy);
      end else begin
        step(1'b0, 1'b0, 0, rdy);
      end
    end
    idle(12, 1'b1);
    check_got("wrap");
    check("wrap_ovf", {63'd0, overflow_flag}, 64'd0);

    // Backpressure: four buffered, fifth dropped.
    got.delete();
    expq.delete();
    for (int i = 0; i < 4; i++) send(rand_in(), 1'b0);
    idle(2, 1'b0);
    check("bp_valid", {63'd0, output_data_valid}, 64'd1);
    check("bp_head", {48'd0, output_data}, {48'd0, expq[0]});
    idle(2, 1'b0);
    check("bp_stable", {48'd0, output_data}, {48'd0, expq[0]});
    x = rand_in();
    step(1'b0, 1'b1, x, 1'b0);
    idle(3, 1'b0);
    check("bp_ovf", {63'd0, overflow_flag}, 64'd1);
    idle(8, 1'b1);
    check_got("bp");

    // Reset with three buffered and two in flight.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_in(), 1'b0);
    step(1'b0, 1'b1, 64'sd2147483648, 1'b0);
    step(1'b1, 1'b1, rand_in(), 1'b0);
    check("rst_valid", {63'd0, output_data_valid}, 64'd0);
    check("rst_sat", {48'd0, sat_count}, 64'd0);
    check("rst_ovf", {63'd0, overflow_flag}, 64'd0);
    step(1'b0, 1'b1, 64'sd7 * 64'sd32768, 1'b1);
    check("lat_k0", {63'd0, output_data_valid}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b1);
    check("lat_k1", {63'd0, output_data_valid}, 64'd0);
    step(1'b0, 1'b0, 0, 1'b1);
    check("lat_k2", {63'd0, output_data_valid}, 64'd1);
    check("lat_data", {48'd0, output_data}, 64'd7);
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
